// File: rtl/ysyx_220066_booth_mul.sv
// Radix-4 Booth multiplier with an iterative 3:2 CSA (Wallace) reduction.
// One operation in flight. Operands are captured at accept; each BUSY cycle
// applies a fixed number of CSA layers to a registered row array, and the
// last BUSY cycle finishes with one carry-propagate adder into the result regs.
module ysyx_220066_booth_mul #(
    parameter int XLEN   = 64,
    parameter int STAGES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);
    localparam int W   = XLEN + 2;          // extended operand width
    localparam int PW  = 2 * XLEN;          // product width (arithmetic mod 2^PW)
    localparam int NPP = XLEN / 2 + 1;      // Booth partial products
    localparam int N   = NPP + 1;           // plus one row collecting the +1s of negation
    localparam int WW  = (XLEN < 32) ? XLEN : 32;

    // Number of 3:2 layers needed to bring n rows down to two.
    function automatic int num_layers(input int n);
        int c;
        int m;
        c = 0;
        m = n;
        while (m > 2) begin
            m = 2 * (m / 3) + m % 3;
            c++;
        end
        return c;
    endfunction

    localparam int TL  = num_layers(N);
    localparam int LPC = (TL + STAGES - 1) / STAGES;   // layers per cycle

    typedef logic [N-1:0][PW-1:0] rows_t;

    // One Wallace layer: each triple of rows becomes sum/carry, leftovers pass
    // through, and the meaningful rows stay packed at the low indices.
    function automatic rows_t csa_layer(input rows_t r);
        rows_t o;
        o = '0;
        for (int g = 0; g < N / 3; g++) begin
            o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                        (r[3*g+1] & r[3*g+2])) << 1;
        end
        for (int g = 3 * (N / 3); g < N; g++) o[g - N/3] = r[g];
        return o;
    endfunction

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nx;
    logic [2:0]      cnt, cnt_nx;
    logic            accept, done;
    logic [W-1:0]    a_q, b_q, a_ext, b_ext;
    logic            mulw_q;
    rows_t           pp, red, rows_q;
    logic [PW-1:0]   sum;
    logic [XLEN-1:0] hi_nx, lo_nx;

    assign mul_ready = (state == IDLE);
    assign accept    = (state == IDLE) && mul_valid && !flush;
    assign done      = (state == BUSY) && (cnt == 3'd0) && !flush;

    // Next-state logic: flush wins, then accept / count down.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
        end else begin
            case (state)
                IDLE: if (mul_valid) begin
                    state_nx = BUSY;
                    cnt_nx   = 3'(STAGES - 1);
                end
                BUSY: if (cnt == 3'd0) state_nx = IDLE;
                      else cnt_nx = cnt - 3'd1;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Operand selection: word ops take bits [WW-1:0], then extend by mode.
    always_comb begin
        logic signed [WW-1:0] aw, bw;
        logic [XLEN-1:0]      a_src, b_src;
        logic                 sa, sb;
        sa    = mul_signed[1];
        sb    = (mul_signed == 2'b11);
        aw    = multiplicand[WW-1:0];
        bw    = multiplier[WW-1:0];
        a_src = multiplicand;
        b_src = multiplier;
        if (mulw) begin
            a_src = sa ? XLEN'(aw) : XLEN'(multiplicand[WW-1:0]);
            b_src = sb ? XLEN'(bw) : XLEN'(multiplier[WW-1:0]);
        end
        a_ext = sa ? {{2{a_src[XLEN-1]}}, a_src} : {2'b00, a_src};
        b_ext = sb ? {{2{b_src[XLEN-1]}}, b_src} : {2'b00, b_src};
    end

    // Booth radix-4 partial products; negation is ~mag plus a 1 in the last row.
    always_comb begin
        logic [PW-1:0] a_pw, mag;
        logic [W:0]    b_pad;
        logic [2:0]    grp;
        logic          one, two, neg;
        pp    = '0;
        a_pw  = {{(PW-W){a_q[W-1]}}, a_q};
        b_pad = {b_q, 1'b0};
        for (int i = 0; i < NPP; i++) begin
            grp  = b_pad[2*i +: 3];
            one  = grp[0] ^ grp[1];
            two  = (grp == 3'b011) || (grp == 3'b100);
            neg  = grp[2] & ~(grp[1] & grp[0]);
            mag  = one ? a_pw : (two ? (a_pw << 1) : '0);
            pp[i] = (neg ? ~mag : mag) << (2 * i);
            pp[N-1][2*i] = neg;
        end
    end

    // This cycle's slice of the CSA tree, then the final carry-propagate add.
    always_comb begin
        logic signed [WW-1:0] sw;
        red = (cnt == 3'(STAGES - 1)) ? pp : rows_q;
        for (int l = 0; l < LPC; l++) red = csa_layer(red);
        sum   = red[0] + red[1];
        sw    = sum[WW-1:0];
        hi_nx = mulw_q ? '0 : sum[PW-1:XLEN];
        lo_nx = mulw_q ? XLEN'(sw) : sum[XLEN-1:0];
    end

    // Control state and result registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            out_valid <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= done;
            if (done) begin
                result_hi <= hi_nx;
                result_lo <= lo_nx;
            end
        end
    end

    // Datapath registers: operands at accept, partial sums while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a_ext;
            b_q    <= b_ext;
            mulw_q <= mulw;
        end
        if (state == BUSY) rows_q <= red;
    end

endmodule
